interrupt_control: RTL and testbench
====================================

INTERRUPT_CONTROL -- requirements
Module: interrupt_control

Interface
REQ-001 fclk  in  1  system clock; all state on posedge fclk.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 cyc_end  in  1  one-fclk strobe marking CPU cycle end (phi2 fall); all sequencing advances only on cyc_end & rdy.
REQ-004 rdy  in  1  high = cycle completes; low = hold all state except synchronizers and NMI edge latch.
REQ-005 resb, nmib, irqb  in  1 each  async external pins, active-low.
REQ-006 sync  in  1  decoder's opcode-fetch cycle flag.
REQ-007 brk_op, wai_op  in  1 each  decoder detected BRK (0x00) / WAI (0xCB) in current opcode.
REQ-008 i_flag  in  1  current status I bit.
REQ-009 seq_active  out  1  interrupt sequence running; decoder forces BRK micro-sequence.
REQ-010 int_kind  out  2  RES=0, NMI=1, IRQ=2, BRK=3 (valid while seq_active).
REQ-011 seq_step  out  3  step 0..6 of the sequence.
REQ-012 stack_wr  out  1  push cycle enable.
REQ-013 vp_n  out  1  vector-pull, active-low.
REQ-014 vec_lo  out  8  low address byte of vector fetch.
REQ-015 push_b  out  1  B value for pushed P.
REQ-016 set_i_clr_d  out  1  one-cycle pulse, set I and clear D.
REQ-017 waiting  out  1  core halted in WAI.

Function
REQ-018 Pins resb/nmib/irqb SHALL pass 2-flop synchronizers on fclk before use.
REQ-019 RES qualifies after synchronized resb is sampled low on 2 consecutive cyc_end; counter saturates at 2.
REQ-020 NMI: synchronized nmib 1->0 sets nmi_pend (sticky, also while rdy low); cleared at step 5 of an NMI sequence.
REQ-021 IRQ: level, pending when irqb low and i_flag=0; not latched.
REQ-022 FSM states IDLE, RES_HOLD, SEQ, WAIT.
REQ-023 IDLE->SEQ on cyc_end&rdy&sync with priority RES > NMI > IRQ > BRK; seq_step=0.
REQ-024 Qualified RES in any state -> RES_HOLD (aborts SEQ/WAIT); RES_HOLD->SEQ(RES) on first cyc_end with resb high.
REQ-025 SEQ: seq_step increments per cyc_end&rdy; after step 6 -> IDLE; set_i_clr_d pulses on that cyc_end.
REQ-026 stack_wr=1 at steps 2,3,4 except int_kind=RES (dummy reads, SP still decremented by decoder).
REQ-027 vp_n=0 at steps 5,6; vec_lo = FC (RES), FA (NMI), FE (IRQ/BRK), plus 1 at step 6.
REQ-028 push_b=1 only for BRK.
REQ-029 NMI hijack: nmi_pend set during IRQ/BRK sequence at step <=4 switches int_kind to NMI before step 5; push_b keeps its BRK value.
REQ-030 Simultaneous NMI edge and IRQ at decision: NMI taken; IRQ remains level-pending.
REQ-031 rdy low: outputs hold; vp_n unchanged.

Reset
REQ-032 On reset: state RES_HOLD with resb already qualified, seq_active=0, seq_step=0, stack_wr=0, vp_n=1, vec_lo=FC, push_b=0, set_i_clr_d=0, waiting=0, nmi_pend=0, synchronizers=1.
REQ-033 Deasserting reset with resb high SHALL start a RES sequence on the first cyc_end.

Configuration
REQ-034 Macro INTC_WAI_EN defined: wai_op at sync enters WAIT (waiting=1); exits on irqb low (even if i_flag=1), nmi_pend, or RES; IRQ taken only if i_flag=0, else resumes at IDLE.
REQ-035 Macro undefined: WAIT state absent, waiting tied 0, wai_op ignored.

Structure
REQ-036 Shared package cpu65_pkg: int_kind_e, vector low-byte constants (FA/FC/FE), fsm state enum.
REQ-037 Sub-module pin_sync (2-flop synchronizer, reset value 1), instantiated three times.

Verification
REQ-038 reset pulse, resb high -> 7 steps, vp_n=0 at steps 5/6, vec_lo FC then FD, stack_wr always 0.
REQ-039 irqb low, i_flag=0, sync -> IRQ sequence, stack_wr steps 2-4, vec_lo FE/FF, push_b=0, set_i_clr_d pulse after step 6.
REQ-040 nmib falls at step 3 of IRQ -> int_kind=NMI, vec_lo FA/FB, nmi_pend cleared at step 5.
REQ-041 resb low 1 cyc_end only -> ignored; low 2 cyc_end mid-SEQ -> RES_HOLD, RES sequence after release.
REQ-042 INTC_WAI_EN: wai_op, i_flag=1, irqb low -> waiting 1->0, no sequence, returns IDLE.
REQ-043 rdy low 5 cycles at step 5 -> vp_n held 0, seq_step held 5.

Source files
------------

// File: rtl/cpu65_pkg.sv
// Shared types and constants for the cpu65 interrupt logic: interrupt kinds,
// vector low bytes and the interrupt controller state encoding.
package cpu65_pkg;

    typedef enum logic [1:0] {
        KIND_RES = 2'd0,
        KIND_NMI = 2'd1,
        KIND_IRQ = 2'd2,
        KIND_BRK = 2'd3
    } int_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RES_HOLD = 2'd1,
        ST_SEQ      = 2'd2,
        ST_WAIT     = 2'd3
    } fsm_state_e;

    localparam logic [7:0] VEC_LO_NMI = 8'hFA;
    localparam logic [7:0] VEC_LO_RES = 8'hFC;
    localparam logic [7:0] VEC_LO_IRQ = 8'hFE;

    // IRQ and BRK share the same vector
    function automatic logic [7:0] vec_base(input int_kind_e kind);
        case (kind)
            KIND_RES: vec_base = VEC_LO_RES;
            KIND_NMI: vec_base = VEC_LO_NMI;
            default:  vec_base = VEC_LO_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for an active-low external pin; resets to the
// inactive (high) level.
module pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], d};
    end

    assign q = r_sync[1];

endmodule

// File: rtl/interrupt_control.sv
// RES/NMI/IRQ/BRK arbitration and the 7-step interrupt sequence of a 65C02-style core.
// Define INTC_WAI_EN to include the WAI halt state; otherwise waiting is tied low.
module interrupt_control
    import cpu65_pkg::*;
(
    input  logic       fclk,
    input  logic       reset,
    input  logic       cyc_end,
    input  logic       rdy,
    input  logic       resb,
    input  logic       nmib,
    input  logic       irqb,
    input  logic       sync,
    input  logic       brk_op,
    input  logic       wai_op,
    input  logic       i_flag,
    output logic       seq_active,
    output logic [1:0] int_kind,
    output logic [2:0] seq_step,
    output logic       stack_wr,
    output logic       vp_n,
    output logic [7:0] vec_lo,
    output logic       push_b,
    output logic       set_i_clr_d,
    output logic       waiting
);
    logic w_resb_s, w_nmib_s, w_irqb_s;

    pin_sync u_sync_resb (.clk(fclk), .rst(reset), .d(resb), .q(w_resb_s));
    pin_sync u_sync_nmib (.clk(fclk), .rst(reset), .d(nmib), .q(w_nmib_s));
    pin_sync u_sync_irqb (.clk(fclk), .rst(reset), .d(irqb), .q(w_irqb_s));

    fsm_state_e r_state, w_state_next;
    int_kind_e  r_kind, w_kind_next;
    logic [2:0] r_step, w_step_next;
    logic       r_push_b, w_push_next;
    logic [1:0] r_res_cnt;
    logic       r_nmib_prev, r_nmi_pend, r_set_i;
    logic       w_adv, w_res_qual, w_irq, w_nmi_clr;

    assign w_adv      = cyc_end & rdy;
    // Second consecutive low sample of resb qualifies the reset
    assign w_res_qual = w_adv & ~w_resb_s & (r_res_cnt != 2'd0);
    assign w_irq      = ~w_irqb_s & ~i_flag;
    assign w_nmi_clr  = w_adv && (r_state == ST_SEQ) && (r_step == 3'd5) && (r_kind == KIND_NMI);

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            r_res_cnt <= 2'd2;
        end else if (w_adv) begin
            if (w_resb_s)                 r_res_cnt <= 2'd0;
            else if (r_res_cnt != 2'd2)   r_res_cnt <= r_res_cnt + 2'd1;
        end
    end

    // Edge latch runs every fclk so an NMI edge is never lost while rdy is low
    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            r_nmib_prev <= 1'b1;
            r_nmi_pend  <= 1'b0;
        end else begin
            r_nmib_prev <= w_nmib_s;
            if (r_nmib_prev & ~w_nmib_s) r_nmi_pend <= 1'b1;
            else if (w_nmi_clr)          r_nmi_pend <= 1'b0;
        end
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RES_HOLD;
            r_kind   <= KIND_RES;
            r_step   <= 3'd0;
            r_push_b <= 1'b0;
            r_set_i  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_kind   <= w_kind_next;
            r_step   <= w_step_next;
            r_push_b <= w_push_next;
            r_set_i  <= w_adv && (r_state == ST_SEQ) && (r_step == 3'd6) && !w_res_qual;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_kind_next  = r_kind;
        w_step_next  = r_step;
        w_push_next  = r_push_b;
        if (w_res_qual) begin
            w_state_next = ST_RES_HOLD;
            w_kind_next  = KIND_RES;
            w_step_next  = 3'd0;
            w_push_next  = 1'b0;
        end else if (w_adv) begin
            case (r_state)
                ST_RES_HOLD: begin
                    w_state_next = ST_SEQ;
                    w_kind_next  = KIND_RES;
                    w_step_next  = 3'd0;
                    w_push_next  = 1'b0;
                end
                ST_IDLE: begin
                    if (sync) begin
                        w_step_next = 3'd0;
                        w_push_next = 1'b0;
                        if (r_nmi_pend) begin
                            w_state_next = ST_SEQ;
                            w_kind_next  = KIND_NMI;
                        end else if (w_irq) begin
                            w_state_next = ST_SEQ;
                            w_kind_next  = KIND_IRQ;
                        end else if (brk_op) begin
                            w_state_next = ST_SEQ;
                            w_kind_next  = KIND_BRK;
                            w_push_next  = 1'b1;
`ifdef INTC_WAI_EN
                        end else if (wai_op) begin
                            w_state_next = ST_WAIT;
`endif
                        end else begin
                            w_push_next = r_push_b;
                        end
                    end
                end
                ST_SEQ: begin
                    if (r_step == 3'd6) begin
                        w_state_next = ST_IDLE;
                        w_step_next  = 3'd0;
                    end else begin
                        w_step_next = r_step + 3'd1;
                        // NMI hijacks an IRQ/BRK before the vector fetch; push_b is left alone
                        if (r_nmi_pend && (r_step <= 3'd4) && (r_kind != KIND_RES))
                            w_kind_next = KIND_NMI;
                    end
                end
`ifdef INTC_WAI_EN
                ST_WAIT: begin
                    if (r_nmi_pend) begin
                        w_state_next = ST_SEQ;
                        w_kind_next  = KIND_NMI;
                        w_step_next  = 3'd0;
                        w_push_next  = 1'b0;
                    end else if (~w_irqb_s) begin
                        w_state_next = i_flag ? ST_IDLE : ST_SEQ;
                        w_kind_next  = i_flag ? r_kind : KIND_IRQ;
                        w_step_next  = 3'd0;
                        w_push_next  = i_flag ? r_push_b : 1'b0;
                    end
                end
`endif
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        seq_active = (r_state == ST_SEQ);
        stack_wr   = seq_active && (r_kind != KIND_RES) && (r_step >= 3'd2) && (r_step <= 3'd4);
        vp_n       = !(seq_active && (r_step >= 3'd5));
        vec_lo     = vec_base(r_kind) | {7'd0, seq_active && (r_step == 3'd6)};
`ifdef INTC_WAI_EN
        waiting    = (r_state == ST_WAIT);
`else
        waiting    = 1'b0;
`endif
    end

`ifndef INTC_WAI_EN
    logic w_unused_wai;
    assign w_unused_wai = wai_op;
`endif

    assign int_kind    = r_kind;
    assign seq_step    = r_step;
    assign push_b      = r_push_b;
    assign set_i_clr_d = r_set_i;

endmodule

// File: tb/tb_interrupt_control.sv
// Directed, table-driven bench for interrupt_control; honours INTC_WAI_EN.
module tb_interrupt_control;

    logic fclk = 1'b0, reset = 1'b1, cyc_end = 1'b0, rdy = 1'b1;
    logic resb = 1'b1, nmib = 1'b1, irqb = 1'b1, sync = 1'b0;
    logic brk_op = 1'b0, wai_op = 1'b0, i_flag = 1'b1;
    logic       seq_active, stack_wr, vp_n, push_b, set_i_clr_d, waiting;
    logic [1:0] int_kind;
    logic [2:0] seq_step;
    logic [7:0] vec_lo;
    logic [18:0] got;
    int tests = 0;
    int fails = 0;

    always #5 fclk = ~fclk;

    interrupt_control dut (
        .fclk(fclk), .reset(reset), .cyc_end(cyc_end), .rdy(rdy),
        .resb(resb), .nmib(nmib), .irqb(irqb), .sync(sync),
        .brk_op(brk_op), .wai_op(wai_op), .i_flag(i_flag),
        .seq_active(seq_active), .int_kind(int_kind), .seq_step(seq_step),
        .stack_wr(stack_wr), .vp_n(vp_n), .vec_lo(vec_lo), .push_b(push_b),
        .set_i_clr_d(set_i_clr_d), .waiting(waiting)
    );

    assign got = {seq_active, int_kind, seq_step, stack_wr, vp_n, vec_lo, push_b, set_i_clr_d, waiting};

    typedef struct {
        string       name;
        logic [6:0]  pins;   // resb nmib irqb sync brk_op i_flag rdy
        logic [18:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [6:0] pins(bit rb, bit nb, bit ib, bit sy, bit bk, bit fi, bit rd);
        return {rb, nb, ib, sy, bk, fi, rd};
    endfunction

    function automatic logic [18:0] outs(bit sa, logic [1:0] k, logic [2:0] s, bit sw, bit vpn,
                                         logic [7:0] vlo, bit pb, bit sic, bit wt);
        return {sa, k, s, sw, vpn, vlo, pb, sic, wt};
    endfunction

    task automatic add(string n, logic [6:0] p, logic [18:0] e);
        vec_t v;
        v.name = n; v.pins = p; v.exp = e;
        vecs.push_back(v);
    endtask

    // One vector per sequence step, expected outputs written from the step table
    task automatic add_steps(string n, logic [6:0] p, logic [1:0] k, bit pb, int s0, int s1);
        for (int s = s0; s <= s1; s++) begin
            logic [7:0] base;
            base = (k == 2'd0) ? 8'hFC : (k == 2'd1) ? 8'hFA : 8'hFE;
            add(n, p, outs(1'b1, k, 3'(s), (k != 2'd0) && (s >= 2) && (s <= 4), !(s >= 5),
                           base + ((s == 6) ? 8'd1 : 8'd0), pb, 1'b0, 1'b0));
        end
    endtask

    task automatic chk(string n, logic [31:0] g, logic [31:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, g, e);
        end
    endtask

    task automatic do_cyc();
        repeat (3) @(negedge fclk);
        cyc_end = 1'b1;
        @(negedge fclk);
        cyc_end = 1'b0;
    endtask

    localparam logic [18:0] RST_OUT = {1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [6:0] q, irq_go, irq_run, hij_n, hij_ni, sim_go, sim_run, rlow, rhigh, rstop;
        q       = pins(1, 1, 1, 0, 0, 1, 1);
        irq_go  = pins(1, 1, 0, 1, 0, 0, 1);
        irq_run = pins(1, 1, 0, 0, 0, 0, 1);
        hij_n   = pins(1, 0, 0, 0, 0, 0, 1);
        hij_ni  = pins(1, 0, 0, 0, 0, 1, 1);
        sim_go  = pins(1, 0, 0, 1, 0, 0, 1);
        sim_run = pins(1, 0, 0, 0, 0, 0, 1);
        rlow    = pins(0, 0, 0, 0, 0, 0, 1);
        rhigh   = sim_run;
        rstop   = pins(1, 0, 0, 0, 0, 0, 0);

        add_steps("res_seq", q, 2'd0, 1'b0, 0, 6);
        add("res_end", q, outs(0, 2'd0, 3'd0, 0, 1, 8'hFC, 0, 1, 0));
        add_steps("irq_seq", irq_go, 2'd2, 1'b0, 0, 0);
        add_steps("irq_seq", irq_run, 2'd2, 1'b0, 1, 6);
        add("irq_end", irq_run, outs(0, 2'd2, 3'd0, 0, 1, 8'hFE, 0, 1, 0));
        add_steps("brk_seq", pins(1, 1, 1, 1, 1, 1, 1), 2'd3, 1'b1, 0, 0);
        add_steps("brk_seq", q, 2'd3, 1'b1, 1, 6);
        add("brk_end", q, outs(0, 2'd3, 3'd0, 0, 1, 8'hFE, 1, 1, 0));
        add_steps("hijack", irq_go, 2'd2, 1'b0, 0, 0);
        add_steps("hijack", irq_run, 2'd2, 1'b0, 1, 3);
        add_steps("hijack_nmi", hij_n, 2'd1, 1'b0, 4, 4);
        add_steps("hijack_nmi", hij_ni, 2'd1, 1'b0, 5, 6);
        add("hijack_end", hij_ni, outs(0, 2'd1, 3'd0, 0, 1, 8'hFA, 0, 1, 0));
        add("nmi_cleared", pins(1, 0, 0, 1, 0, 1, 1), outs(0, 2'd1, 3'd0, 0, 1, 8'hFA, 0, 0, 0));
        add("nmi_release", q, outs(0, 2'd1, 3'd0, 0, 1, 8'hFA, 0, 0, 0));
        add_steps("nmi_vs_irq", sim_go, 2'd1, 1'b0, 0, 0);
        add_steps("nmi_vs_irq", sim_run, 2'd1, 1'b0, 1, 6);
        add("nmi_vs_irq_end", sim_run, outs(0, 2'd1, 3'd0, 0, 1, 8'hFA, 0, 1, 0));
        add_steps("irq_still_pend", sim_go, 2'd2, 1'b0, 0, 0);
        add_steps("res_glitch", rlow, 2'd2, 1'b0, 1, 1);
        add_steps("res_glitch", rhigh, 2'd2, 1'b0, 2, 2);
        add_steps("res_low1", rlow, 2'd2, 1'b0, 3, 3);
        add("res_hold", rlow, outs(0, 2'd0, 3'd0, 0, 1, 8'hFC, 0, 0, 0));
        add("res_hold", rlow, outs(0, 2'd0, 3'd0, 0, 1, 8'hFC, 0, 0, 0));
        add_steps("res_release", rhigh, 2'd0, 1'b0, 0, 6);
        add("res_release_end", rhigh, outs(0, 2'd0, 3'd0, 0, 1, 8'hFC, 0, 1, 0));
        add_steps("rdy_seq", sim_go, 2'd2, 1'b0, 0, 0);
        add_steps("rdy_seq", sim_run, 2'd2, 1'b0, 1, 5);
        for (int i = 0; i < 5; i++) add_steps("rdy_hold", rstop, 2'd2, 1'b0, 5, 5);
        add_steps("rdy_resume", sim_run, 2'd2, 1'b0, 6, 6);
        add("rdy_end", sim_run, outs(0, 2'd2, 3'd0, 0, 1, 8'hFE, 0, 1, 0));

        repeat (3) @(negedge fclk);
        chk("reset_state", 32'(got), 32'(RST_OUT));
        reset = 1'b0;

        foreach (vecs[i]) begin
            {resb, nmib, irqb, sync, brk_op, i_flag, rdy} = vecs[i].pins;
            do_cyc();
            $display("[TB] vec %0d %s out=%h", i, vecs[i].name, got);
            chk(vecs[i].name, 32'(got), 32'(vecs[i].exp));
        end

        // Pulse lasts exactly one fclk
        @(negedge fclk);
        chk("sic_width", 32'(set_i_clr_d), 32'd0);

        // Asynchronous reset in the middle of an IRQ sequence
        {resb, nmib, irqb, sync, brk_op, i_flag, rdy} = irq_go;
        do_cyc();
        sync = 1'b0;
        do_cyc();
        do_cyc();
        chk("pre_reset_step", 32'(got), 32'(outs(1, 2'd2, 3'd2, 1, 1, 8'hFE, 0, 0, 0)));
        @(negedge fclk);
        #2 reset = 1'b1;
        #1 chk("async_reset", 32'(got), 32'(RST_OUT));
        {resb, nmib, irqb, sync, brk_op, i_flag, rdy} = q;
        @(negedge fclk);
        reset = 1'b0;
        do_cyc();
        $display("[TB] first cyc_end after reset out=%h", got);
        chk("res_after_reset", 32'(got), 32'(outs(1, 2'd0, 3'd0, 0, 1, 8'hFC, 0, 0, 0)));
        repeat (7) do_cyc();
        chk("res_after_reset_end", 32'(got), 32'(outs(0, 2'd0, 3'd0, 0, 1, 8'hFC, 0, 1, 0)));

        // WAI with I set: IRQ wakes the core without running a sequence
        sync = 1'b1; wai_op = 1'b1; i_flag = 1'b1;
        do_cyc();
        $display("[TB] wai opcode out=%h", got);
`ifdef INTC_WAI_EN
        chk("wai_enter", 32'({seq_active, waiting}), 32'(2'b01));
`else
        chk("wai_ignored", 32'({seq_active, waiting}), 32'(2'b00));
`endif
        sync = 1'b0; wai_op = 1'b0; irqb = 1'b0;
        do_cyc();
        $display("[TB] wai wake out=%h", got);
        chk("wai_exit", 32'({seq_active, waiting}), 32'(2'b00));
        sync = 1'b1;
        do_cyc();
        chk("wai_idle", 32'({seq_active, waiting, vp_n}), 32'(3'b001));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
